// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the writeback-port arbiter: port count, data width
// and the pointer-width helper used to size the round-robin pointer.
package wb_port_arbiter_pkg;

  localparam int NWPORT = 4;
  localparam int DATA_W = 32;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin multi-grant: scans requesters from the pointer,
// packs up to NWPORT nonzero-address grants onto ports 0.. in scan order.
module rr_multi_grant
  import wb_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int NREQ  = 6,
  parameter int PTRW  = 3
) (
  input  logic [NREQ-1:0]        valid,
  input  logic [NREQ*WIDTH-1:0]  addr,
  input  logic [PTRW-1:0]        ptr,
  output logic [NREQ-1:0]        ready,
  output logic [NWPORT*PTRW-1:0] port_sel,
  output logic [NWPORT-1:0]      port_vld,
  output logic [PTRW-1:0]        last_idx,
  output logic                   any_grant
);

  int               idx;
  logic [2:0]       used;
  logic             dup;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] taken [NWPORT];

  always_comb begin
    ready     = '0;
    port_sel  = '0;
    port_vld  = '0;
    last_idx  = '0;
    any_grant = 1'b0;
    used      = '0;
    dup       = 1'b0;
    cur       = '0;
    idx       = 0;
    for (int p = 0; p < NWPORT; p++) taken[p] = '0;

    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cur = addr[idx*WIDTH +: WIDTH];
      if (valid[idx]) begin
        // Register 0 is hardwired zero: acknowledge it without spending a port.
        if (cur == '0) begin
          ready[idx] = 1'b1;
          last_idx   = PTRW'(idx);
          any_grant  = 1'b1;
        end else if (used < 3'(NWPORT)) begin
          dup = 1'b0;
          for (int p = 0; p < NWPORT; p++) begin
            if (3'(p) < used && taken[p] == cur) dup = 1'b1;
          end
          if (!dup) begin
            ready[idx]                     = 1'b1;
            last_idx                       = PTRW'(idx);
            any_grant                      = 1'b1;
            port_vld[used[1:0]]            = 1'b1;
            port_sel[used[1:0]*PTRW +: PTRW] = PTRW'(idx);
            taken[used[1:0]]               = cur;
            used                           = used + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: round-robin shares the four register-file write ports
// among NREQ sources, registering granted writes for issue one cycle later.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int NREQ  = 6,
  parameter int CNTW  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*WIDTH-1:0]    i_req_addr,
  input  logic [NREQ*DATA_W-1:0]   i_req_data,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [NWPORT-1:0]        o_we,
  output logic [NWPORT*WIDTH-1:0]  o_waddr,
  output logic [NWPORT*DATA_W-1:0] o_wdata,
  output logic [CNTW-1:0]          o_stall_cnt
);

  localparam int PTRW = ptr_width(NREQ);

  logic [PTRW-1:0]        rr;
  logic [NREQ-1:0]        grant_ready;
  logic [NWPORT*PTRW-1:0] port_sel;
  logic [NWPORT-1:0]      port_vld;
  logic [PTRW-1:0]        last_idx;
  logic                   any_grant;
  logic                   stall;
  logic [WIDTH-1:0]       sel_addr [NWPORT];
  logic [DATA_W-1:0]      sel_data [NWPORT];

  rr_multi_grant #(
    .WIDTH(WIDTH),
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_grant (
    .valid    (i_req_valid),
    .addr     (i_req_addr),
    .ptr      (rr),
    .ready    (grant_ready),
    .port_sel (port_sel),
    .port_vld (port_vld),
    .last_idx (last_idx),
    .any_grant(any_grant)
  );

  // Ready is suppressed during reset so nothing is consumed that could be dropped.
  assign o_req_ready = grant_ready & {NREQ{i_rst_n}};
  assign stall       = |(i_req_valid & ~grant_ready);

  always_comb begin
    for (int p = 0; p < NWPORT; p++) begin
      sel_addr[p] = i_req_addr[int'(port_sel[p*PTRW +: PTRW])*WIDTH +: WIDTH];
      sel_data[p] = i_req_data[int'(port_sel[p*PTRW +: PTRW])*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_we        <= '0;
      o_waddr     <= '0;
      o_wdata     <= '0;
      o_stall_cnt <= '0;
      rr          <= '0;
    end else begin
      for (int p = 0; p < NWPORT; p++) begin
        o_we[p] <= port_vld[p];
        if (port_vld[p]) begin
          o_waddr[p*WIDTH +: WIDTH]   <= sel_addr[p];
          o_wdata[p*DATA_W +: DATA_W] <= sel_data[p];
        end
      end
      if (any_grant) begin
        rr <= (last_idx == PTRW'(NREQ-1)) ? '0 : last_idx + 1'b1;
      end
      if (stall && o_stall_cnt != {CNTW{1'b1}}) begin
        o_stall_cnt <= o_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random
// traffic compared against a behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int W = 5;
  localparam int N = 6;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic [N-1:0]     req_valid;
  logic [W-1:0]     req_addr [N];
  logic [31:0]      req_data [N];
  logic [N*W-1:0]   bus_addr;
  logic [N*32-1:0]  bus_data;

  logic [N-1:0]     o_req_ready;
  logic [3:0]       o_we;
  logic [4*W-1:0]   o_waddr;
  logic [127:0]     o_wdata;
  logic [15:0]      o_stall_cnt;

  logic [N-1:0]     sat_valid;
  logic [N*W-1:0]   sat_addr;
  logic [N*32-1:0]  sat_data;
  logic [N-1:0]     sat_ready;
  logic [3:0]       sat_we;
  logic [4*W-1:0]   sat_waddr;
  logic [127:0]     sat_wdata;
  logic [3:0]       sat_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Behavioural model state
  int           m_rr;
  logic [3:0]   m_we;
  logic [W-1:0] m_waddr [4];
  logic [31:0]  m_wdata [4];
  int           m_cnt;
  logic [N-1:0] exp_ready;
  int           exp_np;
  int           exp_sel [4];
  int           exp_last;
  bit           exp_any;

  always #5 i_clk = ~i_clk;

  always_comb begin
    bus_addr = '0;
    bus_data = '0;
    for (int i = 0; i < N; i++) begin
      bus_addr[i*W +: W]   = req_addr[i];
      bus_data[i*32 +: 32] = req_data[i];
    end
  end

  assign sat_addr = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
  assign sat_data = '0;

  wb_port_arbiter #(.WIDTH(W), .NREQ(N), .CNTW(16)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req_valid(req_valid),
    .i_req_addr (bus_addr),
    .i_req_data (bus_data),
    .o_req_ready(o_req_ready),
    .o_we       (o_we),
    .o_waddr    (o_waddr),
    .o_wdata    (o_wdata),
    .o_stall_cnt(o_stall_cnt)
  );

  wb_port_arbiter #(.WIDTH(W), .NREQ(N), .CNTW(4)) dut_sat (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req_valid(sat_valid),
    .i_req_addr (sat_addr),
    .i_req_data (sat_data),
    .o_req_ready(sat_ready),
    .o_we       (sat_we),
    .o_waddr    (sat_waddr),
    .o_wdata    (sat_wdata),
    .o_stall_cnt(sat_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int j, input logic [W-1:0] a, input logic [31:0] d);
    req_valid[j] = 1'b1;
    req_addr[j]  = a;
    req_data[j]  = d;
  endtask

  // Rotate the requester list to start at the pointer, then accept requests
  // in that order under the port-budget and same-cycle duplicate rules.
  task automatic model_grant();
    int order[$];
    int taken[$];
    bit dup;
    exp_ready = '0;
    exp_np    = 0;
    exp_any   = 0;
    exp_last  = 0;
    for (int k = 0; k < N; k++) order.push_back((m_rr + k) % N);
    foreach (order[o]) begin
      int j = order[o];
      if (!req_valid[j]) continue;
      if (req_addr[j] == '0) begin
        exp_ready[j] = 1'b1;
        exp_any      = 1;
        exp_last     = j;
        continue;
      end
      if (taken.size() >= 4) continue;
      dup = 0;
      foreach (taken[t]) if (taken[t] == int'(req_addr[j])) dup = 1;
      if (dup) continue;
      exp_ready[j]    = 1'b1;
      exp_any         = 1;
      exp_last        = j;
      exp_sel[exp_np] = j;
      exp_np++;
      taken.push_back(int'(req_addr[j]));
    end
  endtask

  task automatic model_clock();
    for (int p = 0; p < 4; p++) begin
      m_we[p] = (p < exp_np);
      if (p < exp_np) begin
        m_waddr[p] = req_addr[exp_sel[p]];
        m_wdata[p] = req_data[exp_sel[p]];
      end
    end
    if ((req_valid & ~exp_ready) != '0 && m_cnt < 65535) m_cnt++;
    if (exp_any) m_rr = (exp_last + 1) % N;
    req_valid = req_valid & ~exp_ready;
  endtask

  task automatic model_reset();
    m_rr  = 0;
    m_we  = '0;
    m_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      m_waddr[p] = '0;
      m_wdata[p] = '0;
    end
  endtask

  task automatic checkOutput();
    logic [4*W-1:0] ea;
    logic [127:0]   ed;
    logic [31:0]    ec;
    for (int p = 0; p < 4; p++) begin
      ea[p*W +: W]   = m_waddr[p];
      ed[p*32 +: 32] = m_wdata[p];
    end
    ec = m_cnt;
    check("ready", o_req_ready, exp_ready);
    check("we", o_we, m_we);
    check("waddr", o_waddr, ea);
    check("wdata", o_wdata, ed);
    check("stall_cnt", o_stall_cnt, ec[15:0]);
  endtask

  task automatic sample();
    @(negedge i_clk);
    model_grant();
    checkOutput();
  endtask

  task automatic advance();
    @(posedge i_clk);
    #1;
    model_clock();
  endtask

  initial begin
    req_valid = '0;
    sat_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0;
      req_data[i] = '0;
    end
    model_reset();

    // Reset state, with a request present to confirm ready is held low
    i_rst_n = 1'b0;
    applyStimulus(0, 5'd3, 32'h1234_5678);
    #2;
    check("rst_ready", o_req_ready, 6'b000000);
    check("rst_we", o_we, 4'b0000);
    check("rst_waddr", o_waddr, 20'h0);
    check("rst_stall", o_stall_cnt, 16'h0);
    req_valid = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Three requests granted together, issued next cycle on ports 0..2
    applyStimulus(0, 5'd3, 32'hAAAA_0001);
    applyStimulus(1, 5'd4, 32'hBBBB_0002);
    applyStimulus(2, 5'd5, 32'hCCCC_0003);
    sample();
    check("t1_ready", o_req_ready, 6'b000111);
    advance();
    sample();
    check("t1_we", o_we, 4'b0111);
    check("t1_waddr", o_waddr[14:0], {5'd5, 5'd4, 5'd3});
    check("t1_wdata", o_wdata[95:0], {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
    advance();

    // Pointer now 3: a lone addr-0 request at index 5 wraps it to 0
    applyStimulus(5, 5'd0, 32'hDEAD_0000);
    sample();
    check("t2_zero_ready", o_req_ready, 6'b100000);
    advance();

    // Six distinct requests: four granted, the other two next cycle
    for (int j = 0; j < N; j++) applyStimulus(j, W'(10 + j), $urandom);
    sample();
    check("t2_ready1", o_req_ready, 6'b001111);
    advance();
    sample();
    check("t2_we", o_we, 4'b1111);
    check("t2_stall", o_stall_cnt, 16'd1);
    check("t2_ready2", o_req_ready, 6'b110000);
    advance();

    // Same-cycle duplicate address: only the first in scan order wins
    applyStimulus(0, 5'd7, 32'h7000_0000);
    applyStimulus(1, 5'd7, 32'h7000_0001);
    sample();
    check("t3_ready1", o_req_ready, 6'b000001);
    advance();
    sample();
    check("t3_ready2", o_req_ready, 6'b000010);
    check("t3_we", o_we, 4'b0001);
    check("t3_waddr0", o_waddr[4:0], 5'd7);
    advance();

    // Pointer now 2: addr-0 request consumes no port
    applyStimulus(2, 5'd0, 32'h0000_0002);
    applyStimulus(3, 5'd9, 32'h9999_0003);
    sample();
    check("t4_ready", o_req_ready, 6'b001100);
    advance();
    sample();
    check("t4_we", o_we, 4'b0001);
    check("t4_waddr0", o_waddr[4:0], 5'd9);
    check("t4_wdata0", o_wdata[31:0], 32'h9999_0003);
    advance();

    // Asynchronous reset while all four ports are issuing
    for (int j = 0; j < 4; j++) applyStimulus(j, W'(20 + j), $urandom);
    sample();
    advance();
    check("t5_we_before", o_we, 4'b1111);
    for (int j = 0; j < 4; j++) applyStimulus(j, W'(24 + j), $urandom);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("t5_we_rst", o_we, 4'b0000);
    check("t5_stall_rst", o_stall_cnt, 16'h0);
    check("t5_ready_rst", o_req_ready, 6'b000000);
    check("t5_wdata_rst", o_wdata, 128'h0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Random traffic with small address range to provoke zeros and duplicates
    for (int c = 0; c < 300; c++) begin
      for (int j = 0; j < N; j++) begin
        if (!req_valid[j] && $urandom_range(0, 1) == 1)
          applyStimulus(j, W'($urandom_range(0, 7)), $urandom);
      end
      sample();
      advance();
    end
    req_valid = '0;

    // Five requesters held valid on the 4-bit counter instance
    sat_valid = 6'b011111;
    for (int k = 0; k <= 20; k++) begin
      @(negedge i_clk);
      check("sat_cnt", sat_cnt, (k > 15) ? 4'd15 : 4'(k));
      @(posedge i_clk);
      #1;
    end
    sat_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
